ref_multichan_shallow_fifo: RTL
===============================

REF_MULTICHAN_SHALLOW_FIFO -- requirements
Module: ref_multichan_shallow_fifo

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, meaning the entry width in bits.
REQ-002 The block SHALL have parameter CH_ADDR_WIDTH, default 4, meaning log2 of per-channel depth (16 entries).
REQ-003 The block SHALL have parameter CH_SEL_WIDTH, default 2, meaning log2 of channel count (NUM_CH = 4).
REQ-004 The block SHALL have port clk, input, 1, the single clock.
REQ-005 The block SHALL have port rst, input, 1; reset is synchronous and active-high.
REQ-006 The block SHALL have port wr_en, input, 1, the write request.
REQ-007 The block SHALL have port wr_ch, input, CH_SEL_WIDTH, the target channel for the write.
REQ-008 The block SHALL have port wr_data, input, DATA_WIDTH, the write payload.
REQ-009 The block SHALL have port rd_en, input, 1, the read request.
REQ-010 The block SHALL have port rd_ch, input, CH_SEL_WIDTH, the source channel for the read.
REQ-011 The block SHALL have port rd_valid, output, 1, which qualifies rd_data.
REQ-012 The block SHALL have port rd_data, output, DATA_WIDTH, the read payload.
REQ-013 The block SHALL have port flush, input, NUM_CH, a per-channel empty command.
REQ-014 The block SHALL have port full, output, NUM_CH, the per-channel full flag.
REQ-015 The block SHALL have port empty, output, NUM_CH, the per-channel empty flag.
REQ-016 The block SHALL have port level, output, NUM_CH*(CH_ADDR_WIDTH+1), the per-channel occupancy; channel n is at bits [n*(CH_ADDR_WIDTH+1) +: CH_ADDR_WIDTH+1].
REQ-017 The block SHALL have port err_clr, input, 1, which clears the sticky error flags.
REQ-018 The block SHALL have port overflow, output, NUM_CH, a sticky flag set on a write to a full channel.
REQ-019 The block SHALL have port underflow, output, NUM_CH, a sticky flag set on a read from an empty channel.

Function
REQ-020 Each channel SHALL be an independent circular FIFO in one shared RAM, addressed as {channel, pointer}.
REQ-021 Each channel SHALL keep CH_ADDR_WIDTH+1 bit write/read pointers; empty when the pointers are equal; full when the pointers differ only in the MSB.
REQ-022 Pointer and level arithmetic SHALL be modulo 2^(CH_ADDR_WIDTH+1); pointers wrap silently; level = wr_ptr - rd_ptr.
REQ-023 A write with full[wr_ch]=0 SHALL store wr_data and increment that channel's write pointer on the same edge.
REQ-024 A write with full[wr_ch]=1 SHALL be dropped, set overflow[wr_ch], and leave the pointers unchanged.
REQ-025 A read with empty[rd_ch]=0 SHALL increment that channel's read pointer and return its data one cycle later with rd_valid=1.
REQ-026 A read with empty[rd_ch]=1 SHALL be ignored, set underflow[rd_ch], and produce no rd_valid.
REQ-027 Accept decisions for reads and writes SHALL use the full/empty state registered at the start of the cycle; a write and a read in the same cycle are never bypassed.
REQ-028 A simultaneous accepted write and read on the same channel SHALL leave that channel's level unchanged; with the channel full, the read is accepted and the write dropped.
REQ-029 Outside reads, rd_valid SHALL be 0 and rd_data SHALL hold its last value.
REQ-030 flush[n] SHALL set channel n's read pointer equal to its write pointer on the next edge, and SHALL override any write or read to n in that cycle.
REQ-031 A read accepted one cycle before a flush SHALL still be delivered.
REQ-032 Flags and level SHALL be registered or derived from registered pointers only.
REQ-033 When err_clr=1, the error flags SHALL clear; err_clr SHALL take priority over a setting event in the same cycle.

Reset
REQ-034 rst SHALL zero all pointers and the overflow, underflow, and rd_valid outputs.
REQ-035 After reset, empty SHALL be all ones, full SHALL be 0, and level SHALL be 0.
REQ-036 A read issued in the cycle rst deasserts SHALL be valid.
REQ-037 Reset asserted mid-operation SHALL abort an in-flight read, so rd_valid=0 on the next cycle.
REQ-038 RAM contents SHALL NOT be reset.

Structure
REQ-039 The block SHALL NOT use a shared package; NUM_CH, LEVEL_WIDTH and RAM_ADDR_WIDTH SHALL be local derived constants.
REQ-040 The block SHALL instantiate exactly one sub-module, ref_inferred_shallow_ram, with ADDR_WIDTH=CH_SEL_WIDTH+CH_ADDR_WIDTH, DATA_WIDTH=DATA_WIDTH, FAST_READ=1, and both clocks tied to clk.
REQ-041 Per-channel pointers SHALL be held in a generate loop.
REQ-042 The rd_valid register SHALL sit in the top module, aligned with the RAM's registered read address.

Verification
REQ-043 Reset, then write 0xA0..0xAF to ch1 -> full[1]=1, level[1]=16, other channels empty.
REQ-044 Then read ch1 16 times back-to-back -> rd_data 0xA0..0xAF in order, one cycle after each rd_en, then empty[1]=1.
REQ-045 Write ch2 while full and read ch3 while empty -> overflow=4'b0100, underflow=4'b1000, data intact; err_clr -> both 0.
REQ-046 Interleave writes to ch0 and ch3 across 40 entries with wrap-around, concurrent same-channel read/write -> per-channel order preserved, levels stay exact.
REQ-047 Assert flush[0] in the same cycle as a write to ch0, with ch0 holding 5 entries -> level[0]=0 and the write is discarded.
REQ-048 Assert rst while rd_valid is pending -> rd_valid=0 next cycle and all flags at their reset values.

Source files
------------

// File: rtl/ref_inferred_shallow_ram.sv
// Simple dual-port RAM, inferred array, no reset on contents.
// FAST_READ registers the read address; otherwise the read data is registered.
module ref_inferred_shallow_ram #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 32,
    parameter bit FAST_READ  = 1'b1
) (
    input  logic                  wr_clk,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_clk,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    always_ff @(posedge wr_clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    if (FAST_READ) begin : g_fast
        logic [ADDR_WIDTH-1:0] addr_q;

        always_ff @(posedge rd_clk) begin
            if (rd_en) begin
                addr_q <= rd_addr;
            end
        end

        assign rd_data = mem[addr_q];
    end else begin : g_reg
        logic [DATA_WIDTH-1:0] data_q;

        always_ff @(posedge rd_clk) begin
            if (rd_en) begin
                data_q <= mem[rd_addr];
            end
        end

        assign rd_data = data_q;
    end

endmodule

// File: rtl/ref_multichan_shallow_fifo.sv
// Multi-channel FIFO: NUM_CH independent circular queues in one shared RAM.
// Read data appears one cycle after an accepted read and holds afterwards.
module ref_multichan_shallow_fifo #(
    parameter int DATA_WIDTH    = 32,
    parameter int CH_ADDR_WIDTH = 4,
    parameter int CH_SEL_WIDTH  = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         wr_en,
    input  logic [CH_SEL_WIDTH-1:0]      wr_ch,
    input  logic [DATA_WIDTH-1:0]        wr_data,
    input  logic                         rd_en,
    input  logic [CH_SEL_WIDTH-1:0]      rd_ch,
    output logic                         rd_valid,
    output logic [DATA_WIDTH-1:0]        rd_data,
    input  logic [(1<<CH_SEL_WIDTH)-1:0] flush,
    output logic [(1<<CH_SEL_WIDTH)-1:0] full,
    output logic [(1<<CH_SEL_WIDTH)-1:0] empty,
    output logic [(1<<CH_SEL_WIDTH)*(CH_ADDR_WIDTH+1)-1:0] level,
    input  logic                         err_clr,
    output logic [(1<<CH_SEL_WIDTH)-1:0] overflow,
    output logic [(1<<CH_SEL_WIDTH)-1:0] underflow
);

    localparam int NUM_CH         = 1 << CH_SEL_WIDTH;
    localparam int LEVEL_WIDTH    = CH_ADDR_WIDTH + 1;
    localparam int RAM_ADDR_WIDTH = CH_SEL_WIDTH + CH_ADDR_WIDTH;

    logic [NUM_CH-1:0] wr_sel;
    logic [NUM_CH-1:0] rd_sel;
    logic [NUM_CH-1:0] push;
    logic [NUM_CH-1:0] pop;
    logic [NUM_CH-1:0] ovf_set;
    logic [NUM_CH-1:0] udf_set;

    logic [NUM_CH-1:0][CH_ADDR_WIDTH-1:0] wr_idx;
    logic [NUM_CH-1:0][CH_ADDR_WIDTH-1:0] rd_idx;

    logic [DATA_WIDTH-1:0] ram_data;
    logic [DATA_WIDTH-1:0] data_hold;

    for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
        logic [LEVEL_WIDTH-1:0] wr_ptr;
        logic [LEVEL_WIDTH-1:0] rd_ptr;

        assign wr_sel[n] = wr_en && (wr_ch == CH_SEL_WIDTH'(n));
        assign rd_sel[n] = rd_en && (rd_ch == CH_SEL_WIDTH'(n));

        assign empty[n] = (wr_ptr == rd_ptr);
        assign full[n]  = (wr_ptr[CH_ADDR_WIDTH] != rd_ptr[CH_ADDR_WIDTH]) &&
                          (wr_ptr[CH_ADDR_WIDTH-1:0] == rd_ptr[CH_ADDR_WIDTH-1:0]);
        assign level[n*LEVEL_WIDTH +: LEVEL_WIDTH] = wr_ptr - rd_ptr;

        // A flush on this channel suppresses its write, read and error events.
        assign push[n]    = wr_sel[n] && !full[n] && !flush[n] && !rst;
        assign pop[n]     = rd_sel[n] && !empty[n] && !flush[n] && !rst;
        assign ovf_set[n] = wr_sel[n] && full[n] && !flush[n];
        assign udf_set[n] = rd_sel[n] && empty[n] && !flush[n];

        assign wr_idx[n] = wr_ptr[CH_ADDR_WIDTH-1:0];
        assign rd_idx[n] = rd_ptr[CH_ADDR_WIDTH-1:0];

        always_ff @(posedge clk) begin
            if (rst) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else if (flush[n]) begin
                rd_ptr <= wr_ptr;
            end else begin
                if (push[n]) begin
                    wr_ptr <= wr_ptr + LEVEL_WIDTH'(1);
                end
                if (pop[n]) begin
                    rd_ptr <= rd_ptr + LEVEL_WIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            overflow  <= '0;
            underflow <= '0;
        end else if (err_clr) begin
            overflow  <= '0;
            underflow <= '0;
        end else begin
            overflow  <= overflow | ovf_set;
            underflow <= underflow | udf_set;
        end
    end

    ref_inferred_shallow_ram #(
        .ADDR_WIDTH (RAM_ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .FAST_READ  (1'b1)
    ) u_ram (
        .wr_clk  (clk),
        .wr_en   (|push),
        .wr_addr ({wr_ch, wr_idx[wr_ch]}),
        .wr_data (wr_data),
        .rd_clk  (clk),
        .rd_en   (|pop),
        .rd_addr ({rd_ch, rd_idx[rd_ch]}),
        .rd_data (ram_data)
    );

    // rd_valid tracks the RAM's registered read address, one cycle after the pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= |pop;
        end
    end

    always_ff @(posedge clk) begin
        if (rd_valid) begin
            data_hold <= ram_data;
        end
    end

    assign rd_data = rd_valid ? ram_data : data_hold;

endmodule
